// File: rtl/spi_pkg.sv
// Shared SPI definitions: the four clock-mode encodings and a lookup helper.
package spi_pkg;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE1 = '{cpol: 1'b0, cpha: 1'b1};
   localparam spi_mode_t SPI_MODE2 = '{cpol: 1'b1, cpha: 1'b0};
   localparam spi_mode_t SPI_MODE3 = '{cpol: 1'b1, cpha: 1'b1};

   function automatic spi_mode_t spi_mode(input int unsigned n);
      case (n)
         1:       return SPI_MODE1;
         2:       return SPI_MODE2;
         3:       return SPI_MODE3;
         default: return SPI_MODE0;
      endcase
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin, with rise/fall strobes
// taken one cycle after the second stage.
module spi_sync_edge #(
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
         r_prev <= RST_VAL;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_sync = r_sync;
   assign o_rise = r_sync & ~r_prev;
   assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave with configurable mode, word width and bit order; word-level
// valid/ready handshakes on both directions with overrun/underrun pulses.
module spi_slave_mode
   import spi_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter bit CPOL      = 1'b0,
   parameter bit CPHA      = 1'b0,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              rx_overrun,
   output logic              tx_underrun
);

   localparam int              CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
   localparam spi_mode_t        MODE     = '{cpol: CPOL, cpha: CPHA};
   // bit 0 = sclk, bit 1 = cs_n, bit 2 = mosi
   localparam logic [2:0]       SYNC_IDLE = {1'b0, 1'b1, CPOL};

   logic [2:0] w_pins;
   logic [2:0] w_sync;
   logic [2:0] w_rise;
   logic [2:0] w_fall;

   assign w_pins = {mosi, cs_n, sclk};

   for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      spi_sync_edge #(
         .RST_VAL(SYNC_IDLE[gi])
      ) u_sync (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_async(w_pins[gi]),
         .o_sync (w_sync[gi]),
         .o_rise (w_rise[gi]),
         .o_fall (w_fall[gi])
      );
   end

   logic w_unused_sync;
   assign w_unused_sync = w_sync[0] ^ w_rise[2] ^ w_fall[2];

   logic w_active;
   logic w_mosi_s;
   logic w_cs_fall;
   logic w_cs_rise;
   logic w_lead;
   logic w_trail;
   logic w_sample_edge;
   logic w_shift_edge;

   assign w_active  = ~w_sync[1];
   assign w_mosi_s  = w_sync[2];
   assign w_cs_fall = w_fall[1];
   assign w_cs_rise = w_rise[1];
   assign w_lead    = MODE.cpol ? w_fall[0] : w_rise[0];
   assign w_trail   = MODE.cpol ? w_rise[0] : w_fall[0];

   assign w_sample_edge = (MODE.cpha ? w_trail : w_lead) & w_active;
   assign w_shift_edge  = (MODE.cpha ? w_lead : w_trail) & w_active;

   logic [CNT_W-1:0]  r_bit_cnt;
   logic              r_word_end;
   logic [DATA_W-1:0] r_rx_shift;
   logic [DATA_W-1:0] r_rx_data;
   logic              r_rx_valid;
   logic              r_rx_overrun;
   logic [DATA_W-1:0] w_rx_shift_next;
   logic              w_word_done;

   assign w_rx_shift_next = MSB_FIRST ? {r_rx_shift[DATA_W-2:0], w_mosi_s}
                                      : {w_mosi_s, r_rx_shift[DATA_W-1:1]};
   assign w_word_done     = w_sample_edge & (r_bit_cnt == LAST_BIT);

   // r_word_end marks "last sample taken, next shift edge is the boundary"
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt  <= '0;
         r_word_end <= 1'b0;
         r_rx_shift <= '0;
      end else if (w_cs_rise || w_cs_fall) begin
         r_bit_cnt  <= '0;
         r_word_end <= 1'b0;
         r_rx_shift <= '0;
      end else begin
         if (w_sample_edge) begin
            r_rx_shift <= w_rx_shift_next;
            r_bit_cnt  <= w_word_done ? '0 : r_bit_cnt + CNT_W'(1);
         end
         if (w_word_done) begin
            r_word_end <= 1'b1;
         end else if (w_shift_edge) begin
            r_word_end <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data    <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         r_rx_overrun <= 1'b0;
         if (r_rx_valid && rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         // a word finishing while the previous one is unread is dropped
         if (w_word_done) begin
            if (!r_rx_valid) begin
               r_rx_data  <= w_rx_shift_next;
               r_rx_valid <= 1'b1;
            end else begin
               r_rx_overrun <= 1'b1;
            end
         end
      end
   end

   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;
   logic [DATA_W-1:0] r_tx_shift;
   logic              r_tx_underrun;
   logic              w_tx_load;
   logic              w_word_start;
   logic              w_tx_advance;
   logic              w_tx_bit;

   assign w_tx_load    = tx_valid & ~r_hold_full;
   assign w_word_start = w_cs_fall | (w_shift_edge & r_word_end);
   // the first leading edge of a CPHA=1 word finds the counter at 0 and
   // must keep the bit presented at word start
   assign w_tx_advance = w_shift_edge & ~r_word_end & (r_bit_cnt != '0);
   assign w_tx_bit     = MSB_FIRST ? r_tx_shift[DATA_W-1] : r_tx_shift[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold        <= '0;
         r_hold_full   <= 1'b0;
         r_tx_shift    <= '0;
         r_tx_underrun <= 1'b0;
      end else begin
         r_tx_underrun <= 1'b0;
         if (w_tx_load) begin
            r_hold      <= tx_data;
            r_hold_full <= 1'b1;
         end
         // a load in the same cycle only reaches the hold register, so a
         // word start here sees the previous (empty) state
         if (w_word_start) begin
            if (r_hold_full) begin
               r_tx_shift  <= r_hold;
               r_hold_full <= 1'b0;
            end else begin
               r_tx_shift    <= '0;
               r_tx_underrun <= 1'b1;
            end
         end else if (w_tx_advance) begin
            r_tx_shift <= MSB_FIRST ? {r_tx_shift[DATA_W-2:0], 1'b0}
                                    : {1'b0, r_tx_shift[DATA_W-1:1]};
         end
      end
   end

   assign miso        = w_active & w_tx_bit;
   assign miso_oe     = w_active;
   assign tx_ready    = ~r_hold_full;
   assign rx_data     = r_rx_data;
   assign rx_valid    = r_rx_valid;
   assign rx_overrun  = r_rx_overrun;
   assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Directed bench: four 8-bit MSB-first slaves (modes 0-3) and one 16-bit
// LSB-first mode-0 slave, driven by a behavioural SPI master.
module tb_spi_slave_mode;
   import spi_pkg::*;

   localparam int HALF = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic sclk[5];
   logic cs_n[5];
   logic mosi[5];
   logic miso[5];
   logic oe[5];
   logic tx_valid[5];
   logic tx_ready[5];
   logic rx_valid[5];
   logic rx_ready[5];
   logic ovr[5];
   logic udr[5];
   logic [7:0]  txd8[4];
   logic [7:0]  rxd8[4];
   logic [15:0] txd16;
   logic [15:0] rxd16;

   for (genvar gi = 0; gi < 4; gi++) begin : g_m8
      localparam spi_mode_t M = spi_mode(gi);
      spi_slave_mode #(
         .DATA_W(8), .CPOL(M.cpol), .CPHA(M.cpha), .MSB_FIRST(1'b1)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .sclk(sclk[gi]), .cs_n(cs_n[gi]),
         .mosi(mosi[gi]), .miso(miso[gi]), .miso_oe(oe[gi]),
         .tx_data(txd8[gi]), .tx_valid(tx_valid[gi]), .tx_ready(tx_ready[gi]),
         .rx_data(rxd8[gi]), .rx_valid(rx_valid[gi]), .rx_ready(rx_ready[gi]),
         .rx_overrun(ovr[gi]), .tx_underrun(udr[gi])
      );
   end

   spi_slave_mode #(
      .DATA_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0)
   ) u_dut16 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk[4]), .cs_n(cs_n[4]),
      .mosi(mosi[4]), .miso(miso[4]), .miso_oe(oe[4]),
      .tx_data(txd16), .tx_valid(tx_valid[4]), .tx_ready(tx_ready[4]),
      .rx_data(rxd16), .rx_valid(rx_valid[4]), .rx_ready(rx_ready[4]),
      .rx_overrun(ovr[4]), .tx_underrun(udr[4])
   );

   int total = 0;
   int bad = 0;

   // bench-side view of each instance's configuration
   function automatic int wid(input int idx);
      return (idx == 4) ? 16 : 8;
   endfunction
   function automatic logic cpol_of(input int idx);
      return (idx == 2 || idx == 3);
   endfunction
   function automatic logic cpha_of(input int idx);
      return (idx == 1 || idx == 3);
   endfunction
   function automatic logic msb_of(input int idx);
      return (idx != 4);
   endfunction
   function automatic logic [31:0] rx_of(input int idx);
      return (idx == 4) ? {16'h0, rxd16} : {24'h0, rxd8[idx]};
   endfunction

   int rxv_rise[5] = '{default: 0};
   int ovr_cnt[5]  = '{default: 0};
   int udr_cnt[5]  = '{default: 0};
   logic rxv_prev[5] = '{default: 1'b0};
   logic [31:0] hs_data[$];

   always @(posedge clk) begin
      for (int i = 0; i < 5; i++) begin
         rxv_prev[i] <= rx_valid[i];
         if (rx_valid[i] && !rxv_prev[i]) rxv_rise[i] <= rxv_rise[i] + 1;
         if (ovr[i]) ovr_cnt[i] <= ovr_cnt[i] + 1;
         if (udr[i]) udr_cnt[i] <= udr_cnt[i] + 1;
         if (rx_valid[i] && rx_ready[i]) hs_data.push_back(rx_of(i));
      end
   end

   logic [31:0] m_out[3];
   logic [31:0] m_in[3];

   task automatic master_frame(input int idx, input int nw, input int last_bits);
      int w;
      int nb;
      int pos;
      logic pol;
      w = wid(idx);
      pol = cpol_of(idx);
      cs_n[idx] = 1'b0;
      repeat (8) @(negedge clk);
      for (int k = 0; k < nw; k++) begin
         m_in[k] = '0;
         nb = (k == nw - 1) ? last_bits : w;
         for (int b = 0; b < nb; b++) begin
            pos = msb_of(idx) ? (w - 1 - b) : b;
            if (!cpha_of(idx)) begin
               mosi[idx] = m_out[k][pos];
               repeat (HALF) @(negedge clk);
               m_in[k][pos] = miso[idx];
               sclk[idx] = ~pol;
               repeat (HALF) @(negedge clk);
               sclk[idx] = pol;
            end else begin
               sclk[idx] = ~pol;
               mosi[idx] = m_out[k][pos];
               repeat (HALF) @(negedge clk);
               m_in[k][pos] = miso[idx];
               sclk[idx] = pol;
               repeat (HALF) @(negedge clk);
            end
         end
      end
      repeat (HALF) @(negedge clk);
      cs_n[idx] = 1'b1;
      mosi[idx] = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic load_tx(input int idx, input logic [31:0] data);
      int n;
      n = 0;
      while (tx_ready[idx] !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (tx_ready[idx] !== 1'b1) begin
         bad++;
         $display("FAIL tx_ready_wait[%0d]: got %b want 1", idx, tx_ready[idx]);
      end else begin
         if (idx == 4) txd16 = data[15:0];
         else txd8[idx] = data[7:0];
         tx_valid[idx] = 1'b1;
         @(negedge clk);
         tx_valid[idx] = 1'b0;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         total += 6;
         if (tx_ready[i] !== 1'b1) begin bad++; $display("FAIL reset_tx_ready[%0d]: got %b want 1", i, tx_ready[i]); end
         if (rx_valid[i] !== 1'b0) begin bad++; $display("FAIL reset_rx_valid[%0d]: got %b want 0", i, rx_valid[i]); end
         if (miso[i] !== 1'b0) begin bad++; $display("FAIL reset_miso[%0d]: got %b want 0", i, miso[i]); end
         if (oe[i] !== 1'b0) begin bad++; $display("FAIL reset_miso_oe[%0d]: got %b want 0", i, oe[i]); end
         if (rx_of(i) !== 32'h0) begin bad++; $display("FAIL reset_rx_data[%0d]: got %h want 0", i, rx_of(i)); end
         if (ovr[i] !== 1'b0 || udr[i] !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b%b want 00", i, ovr[i], udr[i]); end
      end
      $display("reset: checked 5 instances");
   endtask

   task automatic test_exchange(input int idx);
      int r0;
      r0 = rxv_rise[idx];
      load_tx(idx, 32'hA5);
      m_out[0] = 32'h3C;
      master_frame(idx, 1, 8);
      total += 3;
      if (m_in[0] !== 32'hA5) begin bad++; $display("FAIL miso_word[%0d]: got %h want a5", idx, m_in[0]); end
      if (rx_of(idx) !== 32'h3C) begin bad++; $display("FAIL rx_data[%0d]: got %h want 3c", idx, rx_of(idx)); end
      if (rxv_rise[idx] - r0 !== 1) begin bad++; $display("FAIL rx_valid_count[%0d]: got %0d want 1", idx, rxv_rise[idx] - r0); end
      $display("exchange mode%0d: miso=%h rx=%h", idx, m_in[0], rx_of(idx));
   endtask

   task automatic test_multiword();
      int r0;
      int base;
      logic [31:0] exp_rx[3];
      logic [31:0] exp_tx[3];
      logic [31:0] got;
      exp_rx = '{32'hBEEF, 32'h1357, 32'hC0DE};
      exp_tx = '{32'h1234, 32'h5678, 32'h9ABC};
      r0 = rxv_rise[4];
      base = hs_data.size();
      load_tx(4, exp_tx[0]);
      m_out = exp_rx;
      fork
         master_frame(4, 3, 16);
         begin
            load_tx(4, exp_tx[1]);
            load_tx(4, exp_tx[2]);
         end
      join
      total++;
      if (rxv_rise[4] - r0 !== 3) begin bad++; $display("FAIL mw_rx_valid_count: got %0d want 3", rxv_rise[4] - r0); end
      for (int k = 0; k < 3; k++) begin
         got = (base + k < hs_data.size()) ? hs_data[base + k] : 32'hDEAD_DEAD;
         total += 2;
         if (m_in[k] !== exp_tx[k]) begin bad++; $display("FAIL mw_miso[%0d]: got %h want %h", k, m_in[k], exp_tx[k]); end
         if (got !== exp_rx[k]) begin bad++; $display("FAIL mw_rx[%0d]: got %h want %h", k, got, exp_rx[k]); end
         $display("multiword %0d: miso=%h rx=%h", k, m_in[k], got);
      end
   endtask

   task automatic test_overrun();
      int r0;
      int o0;
      int base;
      r0 = rxv_rise[0];
      o0 = ovr_cnt[0];
      rx_ready[0] = 1'b0;
      m_out[0] = 32'h11;
      m_out[1] = 32'h22;
      master_frame(0, 2, 8);
      total += 4;
      if (rxd8[0] !== 8'h11) begin bad++; $display("FAIL ovr_rx_data: got %h want 11", rxd8[0]); end
      if (rx_valid[0] !== 1'b1) begin bad++; $display("FAIL ovr_rx_valid_held: got %b want 1", rx_valid[0]); end
      if (rxv_rise[0] - r0 !== 1) begin bad++; $display("FAIL ovr_rx_valid_count: got %0d want 1", rxv_rise[0] - r0); end
      if (ovr_cnt[0] - o0 !== 1) begin bad++; $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt[0] - o0); end
      base = hs_data.size();
      rx_ready[0] = 1'b1;
      @(negedge clk);
      total += 2;
      if (rx_valid[0] !== 1'b0) begin bad++; $display("FAIL ovr_rx_valid_drop: got %b want 0", rx_valid[0]); end
      if (hs_data.size() != base + 1 || hs_data[base] !== 32'h11) begin
         bad++;
         $display("FAIL ovr_handshake: got %0d words want one 11", hs_data.size() - base);
      end
      $display("overrun: rx=%h pulses=%0d", rxd8[0], ovr_cnt[0] - o0);
   endtask

   task automatic test_underrun();
      int u0;
      u0 = udr_cnt[1];
      total++;
      if (tx_ready[1] !== 1'b1) begin bad++; $display("FAIL udr_hold_empty: got %b want 1", tx_ready[1]); end
      m_out[0] = 32'h5A;
      master_frame(1, 1, 8);
      total += 3;
      if (m_in[0] !== 32'h00) begin bad++; $display("FAIL udr_miso: got %h want 00", m_in[0]); end
      if (udr_cnt[1] - u0 !== 1) begin bad++; $display("FAIL udr_pulses: got %0d want 1", udr_cnt[1] - u0); end
      if (rxd8[1] !== 8'h5A) begin bad++; $display("FAIL udr_rx_data: got %h want 5a", rxd8[1]); end
      $display("underrun: miso=%h pulses=%0d", m_in[0], udr_cnt[1] - u0);
   endtask

   task automatic test_partial();
      int r0;
      r0 = rxv_rise[0];
      m_out[0] = 32'hFF;
      master_frame(0, 1, 5);
      total += 2;
      if (rxv_rise[0] - r0 !== 0) begin bad++; $display("FAIL partial_no_valid: got %0d want 0", rxv_rise[0] - r0); end
      if (rxd8[0] !== 8'h11) begin bad++; $display("FAIL partial_rx_kept: got %h want 11", rxd8[0]); end
      load_tx(0, 32'h3C);
      m_out[0] = 32'h81;
      master_frame(0, 1, 8);
      total += 3;
      if (rxd8[0] !== 8'h81) begin bad++; $display("FAIL partial_next_rx: got %h want 81", rxd8[0]); end
      if (rxv_rise[0] - r0 !== 1) begin bad++; $display("FAIL partial_next_valid: got %0d want 1", rxv_rise[0] - r0); end
      if (m_in[0] !== 32'h3C) begin bad++; $display("FAIL partial_next_miso: got %h want 3c", m_in[0]); end
      $display("partial: rx=%h miso=%h", rxd8[0], m_in[0]);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) begin
         sclk[i] = cpol_of(i);
         cs_n[i] = 1'b1;
         mosi[i] = 1'b0;
         tx_valid[i] = 1'b0;
         rx_ready[i] = 1'b1;
      end
      for (int i = 0; i < 4; i++) txd8[i] = '0;
      txd16 = '0;
      test_reset();
      test_exchange(0);
      test_exchange(1);
      test_exchange(2);
      test_exchange(3);
      test_multiword();
      test_overrun();
      test_underrun();
      test_partial();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
